// File: rtl/block_ram_responder_if.sv
// -----------------------------------------------------------------------------
// block_ram_responder_if
// Request/response bundle between a cache-style controller and the block RAM
// responder.
//   baddr [27:0]  block address (byte address [31:4])       controller -> RAM
//   din   [127:0] write block                                controller -> RAM
//   we            1 = write, 0 = read                        controller -> RAM
//   en            request valid, held until hold is seen low controller -> RAM
//   dout  [127:0] registered read block                      RAM -> controller
//   hold          busy; ~hold means ready/complete           RAM -> controller
// -----------------------------------------------------------------------------
interface block_ram_responder_if;
    logic [27:0]  baddr;
    logic [127:0] din;
    logic         we;
    logic         en;
    logic [127:0] dout;
    logic         hold;

    modport master (
        output baddr, din, we, en,
        input  dout, hold
    );

    modport slave (
        input  baddr, din, we, en,
        output dout, hold
    );
endinterface

// File: rtl/block_ram_responder.sv
// -----------------------------------------------------------------------------
// block_ram_responder
// Fixed-latency 128-bit block memory. A request is latched in IDLE, waits
// LATENCY cycles in BUSY, performs the access, then drops hold for exactly one
// RESP cycle before returning to IDLE.
//
// Parameters
//   LATENCY    1..15 cycles from request acceptance to the memory access
//   DEPTH_LOG2 array holds 2**DEPTH_LOG2 blocks; upper address bits alias
// Ports
//   clk        rising-edge clock
//   RESET      synchronous active-high reset (array contents are kept)
//   bus        block_ram_responder_if.slave (baddr, din, we, en, dout, hold)
//   rd_count   [31:0] read accesses   (only with BLOCK_RAM_STATS_EN)
//   wr_count   [31:0] write accesses  (only with BLOCK_RAM_STATS_EN)
// Optional feature macro: BLOCK_RAM_STATS_EN (adds the access counters).
// -----------------------------------------------------------------------------
module block_ram_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   RESET,
    block_ram_responder_if.slave   bus
`ifdef BLOCK_RAM_STATS_EN
    ,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("block_ram_responder: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic [DEPTH_LOG2-1:0]   addr_reg;
    logic [127:0]            din_reg;
    logic                    we_reg;
    logic [127:0]            dout_reg;
    logic                    access;

    // Contents start at zero and survive reset.
    logic [127:0] mem [DEPTH] = '{default: '0};

    // The access edge is the last BUSY cycle; a reset on that edge wins and
    // the transaction is dropped without touching the array.
    assign access = (state_reg == BUSY) && (cnt_reg == 4'd0) && !RESET;

    // hold mirrors en whenever the FSM could accept (IDLE, or being reset),
    // so a fresh request is never mistaken for a completion.
    assign bus.hold = (RESET || state_reg == IDLE) ? bus.en : (state_reg == BUSY);
    assign bus.dout = dout_reg;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            din_reg   <= '0;
            we_reg    <= 1'b0;
            dout_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.en) begin
                        addr_reg  <= bus.baddr[DEPTH_LOG2-1:0];
                        din_reg   <= bus.din;
                        we_reg    <= bus.we;
                        cnt_reg   <= 4'(LATENCY - 1);
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        if (!we_reg) begin
                            dout_reg <= mem[addr_reg];
                        end
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Write port kept in its own block (no reset) so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (access && we_reg) begin
            mem[addr_reg] <= din_reg;
        end
    end

    // Upper address bits deliberately alias; fold them so they are consumed.
    generate
        if (DEPTH_LOG2 < 28) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^bus.baddr[27:DEPTH_LOG2];
        end
    endgenerate

`ifdef BLOCK_RAM_STATS_EN
    always_ff @(posedge clk) begin
        if (RESET) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (access) begin
            if (we_reg) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_block_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_block_ram_responder
// Directed scenarios followed by randomized traffic, checked against a simple
// reference: an address-indexed array of blocks, a "last read" value for dout,
// and the rule that a completion appears LATENCY+1 cycles after acceptance.
// -----------------------------------------------------------------------------
module tb_block_ram_responder;

    localparam int LATENCY    = 4;
    localparam int DEPTH_LOG2 = 10;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk;
    logic RESET;
    int   cyc;

    block_ram_responder_if bus ();

`ifdef BLOCK_RAM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    block_ram_responder #(
        .LATENCY    (LATENCY),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
`ifdef BLOCK_RAM_STATS_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Reference state
    logic [127:0] ref_mem [DEPTH];
    logic [127:0] ref_dout;
    int           ref_rd;
    int           ref_wr;
    int           last_resp;
    int           txn_no;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction. Called at a negedge (or after setup); drives
    // the request at the start of the next cycle, which becomes cycle 0.
    // drop_cyc > 0 lowers en at that cycle; request fields are scrambled while
    // busy to show the latched copy is what gets used.
    task automatic run_txn(input bit w, input logic [27:0] a, input logic [127:0] d,
                           input int drop_cyc);
        int lat;
        bit seen;
        @(posedge clk); #1;
        bus.en    = 1'b1;
        bus.we    = w;
        bus.baddr = a;
        bus.din   = d;
        @(negedge clk);
        check("hold_accept", {127'd0, bus.hold}, 128'd1);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= LATENCY + 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (c == drop_cyc) bus.en = 1'b0;
            bus.baddr = 28'($urandom);
            bus.din   = {$urandom, $urandom, $urandom, $urandom};
            bus.we    = 1'($urandom);
            @(negedge clk);
            if (!bus.hold) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check("latency", 128'(lat), 128'(LATENCY + 1));
        if (w) begin
            ref_mem[a[DEPTH_LOG2-1:0]] = d;
            ref_wr++;
        end else begin
            ref_dout = ref_mem[a[DEPTH_LOG2-1:0]];
            ref_rd++;
        end
        check("dout_resp", bus.dout, ref_dout);
        last_resp = cyc;
        txn_no++;
        $display("txn %0d: %s baddr=%h data=%h lat=%0d dout=%h", txn_no,
                 w ? "WR" : "RD", a, w ? d : ref_dout, lat, bus.dout);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.en = 1'b0;
            @(negedge clk);
            check("hold_idle", {127'd0, bus.hold}, 128'd0);
            check("dout_stable", bus.dout, ref_dout);
        end
    endtask

    task automatic pulse_reset(input bit en_during);
        @(posedge clk); #1;
        RESET  = 1'b1;
        bus.en = en_during;
        @(negedge clk);
        check("hold_eq_en_rst", {127'd0, bus.hold}, {127'd0, en_during});
        @(posedge clk); #1;
        RESET  = 1'b0;
        bus.en = 1'b0;
        ref_dout = '0;
        ref_rd   = 0;
        ref_wr   = 0;
        @(negedge clk);
        check("dout_after_rst", bus.dout, 128'd0);
        check("hold_after_rst", {127'd0, bus.hold}, 128'd0);
    endtask

    initial begin
        logic [127:0] blk;
        int           t1;
        n_checks = 0;
        n_fail   = 0;
        txn_no   = 0;
        ref_dout = '0;
        ref_rd   = 0;
        ref_wr   = 0;
        last_resp = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        RESET     = 1'b1;
        bus.en    = 1'b0;
        bus.we    = 1'b0;
        bus.baddr = '0;
        bus.din   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hold_en0", {127'd0, bus.hold}, 128'd0);
        check("rst_dout", bus.dout, 128'd0);
        bus.en = 1'b1;
        #1;
        check("rst_hold_en1", {127'd0, bus.hold}, 128'd1);
        @(posedge clk); #1;
        RESET  = 1'b0;
        bus.en = 1'b0;
        idle(2);

        // Write then read back one block
        blk = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        run_txn(1'b1, 28'h0000010, blk, 0);
        idle(2);
        run_txn(1'b0, 28'h0000010, 128'd0, 0);
        idle(2);

        // Writeback then allocate with en held continuously
        run_txn(1'b1, 28'h0000030, 128'h5, 0);
        idle(1);
        run_txn(1'b1, 28'h0000020, 128'h1, 0);
        t1 = last_resp;
        run_txn(1'b0, 28'h0000030, 128'd0, 0);
        check("b2b_spacing", 128'(last_resp - t1), 128'd6);
        check("b2b_dout", bus.dout, 128'h5);
        idle(2);

        // en dropped during BUSY does not abort
        run_txn(1'b0, 28'h0000010, 128'd0, 2);
        check("drop_en_dout", bus.dout, blk);
        idle(2);

        // Reset in cycle 3 of a write abandons it
        @(posedge clk); #1;
        bus.en    = 1'b1;
        bus.we    = 1'b1;
        bus.baddr = 28'h0000040;
        bus.din   = 128'hFF;
        repeat (2) begin
            @(posedge clk); #1;
        end
        pulse_reset(1'b1);
        idle(LATENCY + 2);
        run_txn(1'b0, 28'h0000040, 128'd0, 0);
        check("rst_abandon", bus.dout, 128'd0);
        idle(1);

        // Aliasing
        run_txn(1'b1, 28'h0000400, 128'hA5, 0);
        idle(1);
        run_txn(1'b0, 28'h0000000, 128'd0, 0);
        check("alias_dout", bus.dout, 128'hA5);
        idle(1);

        // Randomized traffic over a few aliased indices
        for (int k = 0; k < 40; k++) begin
            logic [27:0] a;
            a = {18'($urandom), 10'($urandom_range(0, 7))};
            run_txn(1'($urandom), a, {$urandom, $urandom, $urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LATENCY)) : 0);
            idle(int'($urandom_range(0, 2)));
        end

`ifdef BLOCK_RAM_STATS_EN
        idle(1);
        check("wr_count", 128'(wr_count), 128'(ref_wr));
        check("rd_count", 128'(rd_count), 128'(ref_rd));
        pulse_reset(1'b0);
        check("wr_count_rst", 128'(wr_count), 128'd0);
        check("rd_count_rst", 128'(rd_count), 128'd0);
        run_txn(1'b1, 28'h1, 128'h11, 0);
        run_txn(1'b1, 28'h2, 128'h22, 0);
        run_txn(1'b1, 28'h3, 128'h33, 0);
        run_txn(1'b0, 28'h1, 128'd0, 0);
        run_txn(1'b0, 28'h2, 128'd0, 0);
        idle(1);
        check("wr_count3", 128'(wr_count), 128'd3);
        check("rd_count2", 128'(rd_count), 128'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/block_ram_responder.md
BLOCK_RAM_RESPONDER -- requirements
Module: block_ram_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to the memory access; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: the array holds 2^DEPTH_LOG2 128-bit blocks.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port baddr  input  28  block address, i.e. byte address [31:4].
REQ-006 SHALL have port din  input  128  write block.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port en  input  1  request valid; the controller holds it with baddr/din/we until it sees hold low.
REQ-009 SHALL have port dout  output  128  read block; registered.
REQ-010 SHALL have port hold  output  1  busy; the controller treats ~hold as ready.

Function
REQ-011 SHALL implement the states IDLE, BUSY and RESP.
REQ-012 IDLE: hold SHALL equal en combinationally; with en=1, SHALL latch baddr[DEPTH_LOG2-1:0], din and we, load cnt=LATENCY-1, and go to BUSY.
REQ-013 BUSY: hold SHALL be 1; cnt decrements each cycle; on the edge where cnt==0, SHALL perform the access and go to RESP.
REQ-014 Access: a write SHALL store the full latched 128-bit block with no byte enables; a read SHALL load dout from the array.
REQ-015 RESP: hold SHALL be 0 for exactly one cycle, then go to IDLE.
REQ-016 In RESP, dout SHALL hold the completed read data; write completion SHALL leave dout unchanged.
REQ-017 Latency: with en first sampled high in cycle 0, hold SHALL be low in cycle LATENCY+1.
REQ-018 Back-to-back requests SHALL be accepted: en still high in the IDLE cycle after RESP starts a new transaction with the then-current baddr/we/din (writeback followed by allocate).
REQ-019 Request changes: en dropping, or baddr/din/we changing, during BUSY SHALL NOT abort or alter the latched transaction; RESP still occurs.
REQ-020 Address aliasing: baddr bits above DEPTH_LOG2-1 SHALL be ignored, so blocks alias modulo 2^DEPTH_LOG2; no error is signalled.
REQ-021 Read-after-write to the same block on consecutive transactions SHALL return the newly written data.
REQ-022 dout SHALL change only on a read access, or on reset.
REQ-023 Array contents SHALL initialise to all zeros at time zero.

Reset
REQ-024 RESET=1 SHALL force state=IDLE, cnt=0, dout=0 and the latched request to 0 on the next edge.
REQ-025 Reset SHALL NOT clear the array contents.
REQ-026 Reset in BUSY SHALL abandon the transaction; no write is committed and no RESP is issued.
REQ-027 While RESET=1, hold SHALL equal en, per the IDLE rule.

Configuration
REQ-028 With macro BLOCK_RAM_STATS_EN defined, SHALL add output ports rd_count (32) and wr_count (32).
REQ-029 rd_count SHALL increment at each read access; wr_count SHALL increment at each write access.
REQ-030 Both counters SHALL reset to 0 and wrap at 2^32.
REQ-031 Without BLOCK_RAM_STATS_EN, the ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-032 LATENCY=4: write baddr=0x0000010, din=0xDEADBEEF_01234567_89ABCDEF_CAFEF00D, en=1 at cycle 0 -> hold=1 in cycles 0-4, hold=0 in cycle 5; then read 0x0000010 -> dout equals that block in its RESP cycle.
REQ-033 Writeback then allocate with en held continuously: write 0x0000020 = 128'h1, then read 0x0000030 (holds 128'h5) -> two RESP pulses 6 cycles apart; dout=128'h5.
REQ-034 Read baddr=0x0000010 with en dropped in cycle 2 -> RESP still in cycle 5; dout = stored block.
REQ-035 RESET asserted in cycle 3 of a write of 128'hFF to 0x0000040 -> state IDLE; a later read of 0x0000040 returns the prior contents (0); dout=0 after reset.
REQ-036 Aliasing with DEPTH_LOG2=10: write 128'hA5 to 0x0000400, read 0x0000000 -> dout=128'hA5.
REQ-037 With BLOCK_RAM_STATS_EN: 3 writes + 2 reads -> wr_count=3, rd_count=2; after RESET both are 0.
